// File: rtl/wptr_full_lvl.sv
// wptr_full_lvl
//   Write-side pointer and flag generator for a dual-clock Gray-pointer FIFO.
//   It keeps the binary write count and the Gray write pointer, and it
//   registers the full, almost-full, fill-level and sticky-overflow flags.
//   Every output is registered, so no input has a combinational path to an
//   output.
//
// Ports
//   wclk          write-domain clock (rising edge)
//   wrst          synchronous, active-high reset
//   winc          write request; accepted only while wfull = 0
//   wq2_rptr      Gray read pointer, already synchronised into wclk
//   waf_thresh    programmable almost-full threshold, in words
//   waf_thresh_en 1: use waf_thresh; 0: use AF_RESET
//   wovf_clr      clears woverflow (a set in the same cycle takes priority)
//   waddr         binary memory write address
//   wptr          Gray write pointer, sent to the read-side synchroniser
//   wfull         full flag
//   walmost_full  set when the fill level is at or above the threshold
//   wlevel        fill level, 0..DEPTH, a pessimistic value
//   woverflow     sticky flag: a write was attempted while full
module wptr_full_lvl #(
  parameter int ADDRSIZE = 7,
  parameter int AF_RESET = 2**ADDRSIZE - 4
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   waf_thresh,
  input  logic                waf_thresh_en,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam logic [ADDRSIZE:0] AF_DEF = (ADDRSIZE+1)'(AF_RESET);

  logic [ADDRSIZE:0] wbin, wbinnext, wgraynext, rbin_s, lvl_next, thr;
  logic              winc_ok, wfull_val, waf_val, set_ovf;

  // Gray to binary conversion: each binary bit is the XOR of all Gray bits
  // at or above that bit position.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++)
      rbin_s[i] = ^(wq2_rptr >> i);
  end

  assign winc_ok   = winc & ~wfull;
  assign set_ovf   = winc & wfull;
  assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, winc_ok};
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;

  // Full when the next write pointer has lapped the read pointer by exactly
  // one pass. In Gray code, this means the top two bits are inverted and
  // the remaining bits are equal.
  assign wfull_val = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                    wq2_rptr[ADDRSIZE-2:0]});

  // The level comes from the same wbinnext as the full flag. This keeps
  // wlevel, wfull and walmost_full consistent with each other on every edge.
  assign lvl_next = wbinnext - rbin_s;
  assign thr      = waf_thresh_en ? waf_thresh : AF_DEF;
  assign waf_val  = (lvl_next >= thr);

  assign waddr = wbin[ADDRSIZE-1:0];

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= wfull_val;
      walmost_full <= waf_val;
      wlevel       <= lvl_next;
      woverflow    <= set_ovf | (woverflow & ~wovf_clr);
    end
  end

endmodule

// File: tb/tb_wptr_full_lvl.sv
module tb_wptr_full_lvl;
  localparam int A     = 3;
  localparam int DEPTH = 8;

  logic         wclk = 1'b0;
  logic         wrst, winc, waf_thresh_en, wovf_clr;
  logic [A:0]   wq2_rptr, waf_thresh;
  logic [A-1:0] waddr;
  logic [A:0]   wptr, wlevel;
  logic         wfull, walmost_full, woverflow;

  int checks = 0;
  int passes = 0;

  // Behavioural model: the total number of accepted writes, the total
  // number of reads, and the registered flags that follow from them.
  int   m_wcnt = 0, m_rcnt = 0, m_lvl = 0;
  bit   m_full = 0, m_af = 0, m_ovf = 0;
  logic [A:0] prev_wptr = '0;

  wptr_full_lvl #(.ADDRSIZE(A)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr),
    .waf_thresh(waf_thresh), .waf_thresh_en(waf_thresh_en),
    .wovf_clr(wovf_clr), .waddr(waddr), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  function automatic logic [A:0] gray(input int b);
    logic [A:0] x;
    x = b[A:0];
    return (x >> 1) ^ x;
  endfunction

  task automatic check(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", name, obs, exp);
  endtask

  task automatic set_rd(input int r);
    m_rcnt   = r;
    wq2_rptr = gray(r);
  endtask

  // Advances the model by one clock edge, then compares every DUT output
  // with the model.
  task automatic tick();
    int thr;
    if (wrst) begin
      m_wcnt = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      m_ovf  = (winc && m_full) || (m_ovf && !wovf_clr);
      if (winc && !m_full) m_wcnt++;
      m_lvl  = m_wcnt - m_rcnt;
      m_full = (m_lvl == DEPTH);
      thr    = waf_thresh_en ? int'(waf_thresh) : DEPTH - 4;
      m_af   = (m_lvl >= thr);
    end
    @(posedge wclk); #1;
    check("wptr",   wptr,         gray(m_wcnt));
    check("waddr",  waddr,        m_wcnt % DEPTH);
    check("wfull",  wfull,        m_full);
    check("waf",    walmost_full, m_af);
    check("wlevel", wlevel,       m_lvl);
    check("wovf",   woverflow,    m_ovf);
    if (!wrst) check("wptr_1bit", ($countones(wptr ^ prev_wptr) <= 1), 1);
    prev_wptr = wptr;
  endtask

  task automatic do_reset();
    wrst = 1; winc = 0; wovf_clr = 0; set_rd(0);
    tick();
    wrst = 0;
  endtask

  logic [A:0] seq [8];

  initial begin
    seq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
    waf_thresh_en = 0; waf_thresh = '0;
    do_reset();
    check("rst_wptr", wptr, 0);
    check("rst_lvl",  wlevel, 0);

    // Fill from empty. The Gray pointer walks the known sequence.
    winc = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("fill_seq", wptr, seq[i]);
    end
    check("full_flag", wfull, 1);
    check("full_lvl",  wlevel, 8);
    check("full_addr", waddr, 0);

    // Writes while full are dropped and set the overflow flag.
    for (int i = 0; i < 3; i++) tick();
    check("ovf_hold_ptr", wptr, 12);
    check("ovf_set", woverflow, 1);
    wovf_clr = 1; tick();
    check("ovf_set_wins", woverflow, 1);
    winc = 0; tick();
    check("ovf_clr", woverflow, 0);
    wovf_clr = 0;

    // One read frees a slot, and one more write fills the FIFO again.
    set_rd(1); tick();
    check("rd_unfull", wfull, 0);
    check("rd_lvl", wlevel, 7);
    winc = 1; tick();
    check("refull", wfull, 1);
    check("refull_ptr", wptr, 13);

    // Almost-full at a programmable threshold of 5.
    waf_thresh_en = 1; waf_thresh = 5;
    do_reset();
    winc = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("af5", walmost_full, (i >= 5));
    end
    // A threshold above DEPTH never asserts almost-full.
    waf_thresh = 9;
    do_reset();
    winc = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("af9", walmost_full, 0);
    end
    // A threshold of 0 asserts almost-full immediately.
    waf_thresh = 0;
    do_reset();
    tick();
    check("af0", walmost_full, 1);

    // Random traffic with a legal, one-step Gray read pointer.
    waf_thresh_en = 0;
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      winc     = ($urandom_range(0, 99) < 60);
      wovf_clr = ($urandom_range(0, 15) == 0);
      if (m_rcnt < m_wcnt && $urandom_range(0, 99) < 45) set_rd(m_rcnt + 1);
      tick();
      check("lvl_bound", (wlevel <= DEPTH), 1);
    end
    winc = 0; wovf_clr = 0;

    // Reset in the middle of operation, with level 6 and overflow set.
    do_reset();
    winc = 1;
    for (int i = 0; i < 9; i++) tick();
    winc = 0;
    set_rd(1); tick();
    set_rd(2); tick();
    check("pre_rst_lvl", wlevel, 6);
    check("pre_rst_ovf", woverflow, 1);
    do_reset();
    check("mid_rst_zero", {wptr, wfull, walmost_full, wlevel, woverflow}, 0);
    check("mid_rst_addr", waddr, 0);
    winc = 1; tick();
    check("post_rst_ptr", wptr, 1);
    check("post_rst_addr", waddr, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
